avr_spi_slave: RTL

- SPI mode-0 slave on the link from the on-board AVR to the FPGA. It sits directly downstream of the CCLK-based ready detector.
- Consumes the detector's `ready` output. While the AVR has not finished configuring the FPGA (`ready` low), the block ignores the bus and keeps `miso` undriven.
- Once ready, it shifts in full bytes from the AVR and delivers each one with a 1-cycle `done` strobe. It shifts out a byte supplied by the fabric at the same time.

---
 rtl/avr_spi_slave.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/avr_spi_slave.sv
// SPI mode-0 slave for the AVR-to-FPGA link, gated by the CCLK ready detector.
// Define AVR_SPI_OVERRUN_EN to add rx_ack/overrun receive-overrun tracking.
module avr_spi_slave #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ready,
    input  logic       ss,
    input  logic       sck,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       done,
    output logic       busy
`ifdef AVR_SPI_OVERRUN_EN
    ,
    input  logic       rx_ack,
    output logic       overrun
`endif
);

    typedef enum logic [1:0] {
        ST_OFF,
        ST_IDLE,
        ST_XFER
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] ss_sync_q, sck_sync_q, mosi_sync_q;
    logic                   sck_prev_q;
    logic                   ss_s, sck_s, mosi_s, sck_rise, sck_fall;

    logic [2:0] cnt_q, cnt_d;
    logic [7:0] rx_q, rx_d;
    logic [7:0] tx_q, tx_d;
    logic [7:0] dout_q, dout_d;
    logic       miso_q, miso_d;
    logic       done_q, done_d;
    logic       byte_q, byte_d;
    logic       skip_q, skip_d;

    assign ss_s     = ss_sync_q[SYNC_STAGES-1];
    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev_q;
    assign sck_fall = ~sck_s & sck_prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ss_sync_q   <= '1;
            sck_sync_q  <= '0;
            mosi_sync_q <= '0;
            sck_prev_q  <= 1'b0;
        end else begin
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss};
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            sck_prev_q  <= sck_s;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_OFF;
            cnt_q   <= 3'd0;
            rx_q    <= 8'd0;
            tx_q    <= 8'd0;
            dout_q  <= 8'd0;
            miso_q  <= 1'b0;
            done_q  <= 1'b0;
            byte_q  <= 1'b0;
            skip_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rx_q    <= rx_d;
            tx_q    <= tx_d;
            dout_q  <= dout_d;
            miso_q  <= miso_d;
            done_q  <= done_d;
            byte_q  <= byte_d;
            skip_q  <= skip_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rx_d    = rx_q;
        tx_d    = tx_q;
        dout_d  = dout_q;
        miso_d  = miso_q;
        done_d  = 1'b0;
        byte_d  = 1'b0;
        skip_d  = skip_q;

        case (state_q)
            ST_OFF: begin
                cnt_d = 3'd0;
                if (ready) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                cnt_d  = 3'd0;
                tx_d   = din;
                miso_d = din[7];
                skip_d = 1'b0;
                if (!ss_s) state_d = ST_XFER;
            end
            ST_XFER: begin
                if (ss_s) begin
                    state_d = ST_IDLE;
                    cnt_d   = 3'd0;
                end else begin
                    if (sck_rise) begin
                        rx_d  = {rx_q[6:0], mosi_s};
                        cnt_d = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) byte_d = 1'b1;
                    end
                    // The fall that closes a byte arrives after the reload; it must
                    // not shift away din[7] before the next byte's first rise.
                    if (sck_fall) begin
                        if (skip_q) begin
                            skip_d = 1'b0;
                        end else begin
                            tx_d   = {tx_q[6:0], 1'b0};
                            miso_d = tx_q[6];
                        end
                    end
                    if (done_q) begin
                        tx_d   = din;
                        miso_d = din[7];
                        skip_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_OFF;
        endcase

        if (byte_q) begin
            dout_d = rx_q;
            done_d = 1'b1;
        end

        if (!ready) begin
            state_d = ST_OFF;
            cnt_d   = 3'd0;
            byte_d  = 1'b0;
        end
    end

    assign miso    = miso_q;
    assign miso_oe = (state_q != ST_OFF);
    assign busy    = (state_q == ST_XFER);
    assign dout    = dout_q;
    assign done    = done_q;

`ifdef AVR_SPI_OVERRUN_EN
    logic pend_q, pend_d, ovr_q, ovr_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            ovr_q  <= ovr_d;
        end
    end

    // pend/ovr update on the same edge that raises done, so overrun lines up with it.
    always_comb begin
        pend_d = pend_q;
        ovr_d  = ovr_q;
        if (rx_ack) pend_d = 1'b0;
        if (rx_ack && state_q == ST_IDLE) ovr_d = 1'b0;
        if (byte_q) begin
            pend_d = 1'b1;
            if (pend_q && !rx_ack) ovr_d = 1'b1;
        end
    end

    assign overrun = ovr_q;
`endif

endmodule
